mem_bus_bridge: RTL
===================

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of REQ cycles without bus_ready before abort; legal range 2..255.
REQ-002 Port clk  in  1  is the single clock; all state updates on its rising edge.
REQ-003 Port rst  in  1  is the reset: asynchronous, active-high.
REQ-004 Port read  in  1  is the load request from the memory controller.
REQ-005 Port write  in  1  is the store request from the memory controller.
REQ-006 Port address  in  32  is the byte address; bits [1:0] are ignored on the bus.
REQ-007 Port dataMemIn  in  32  is the store data.
REQ-008 Port maskByte  in  4  is the store byte enables.
REQ-009 Port dataMemOut  out  32  is the registered load word returned to the controller.
REQ-010 Port stall  out  1  freezes the pipeline while an access is outstanding.
REQ-011 Port busErr  out  1  is a one-cycle timeout error pulse.
REQ-012 Ports bus_valid, bus_we (out 1), bus_addr (out 32), bus_wdata (out 32) and bus_be (out 4) form the bus request.
REQ-013 Ports bus_ready (in 1) and bus_rdata (in 32) form the bus response.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-015 IDLE with (read|write) SHALL latch the request into registers and move to REQ; write SHALL win if both are high.
REQ-016 bus_addr SHALL be {address[31:2],2'b00}; bus_we=write; bus_be=maskByte for writes and 4'b1111 for reads; bus_wdata=dataMemIn.
REQ-017 A write with maskByte==0 SHALL issue no bus transaction, SHALL stay in IDLE, and SHALL NOT assert stall.
REQ-018 bus_valid SHALL be registered, high throughout REQ, and all bus_* SHALL hold stable until bus_ready is sampled high.
REQ-019 REQ with bus_ready=1 SHALL go to DONE; on a read, dataMemOut SHALL capture bus_rdata on that edge.
REQ-020 DONE SHALL last one cycle, deassert bus_valid, and return to IDLE; a new request is not accepted in DONE.
REQ-021 stall SHALL be combinational: (IDLE & (read|write) & !(write & maskByte==0)) | REQ.
REQ-022 Minimum latency SHALL be: request cycle N, REQ at N+1, DONE at N+2; stall high at N and N+1, low at N+2.
REQ-023 dataMemOut SHALL hold its value until the next completed read; writes SHALL NOT change it.

Reset
REQ-024 rst SHALL force, asynchronously: state=IDLE; bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0; dataMemOut=0; busErr=0; timeout counter=0.
REQ-025 Reset during REQ SHALL drop bus_valid immediately and discard the access; the bus is responsible for tolerating an abandoned request.
REQ-026 After rst deasserts, the first rising edge SHALL evaluate IDLE normally.

Configuration
REQ-027 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to REQ and increment each REQ cycle without bus_ready.
REQ-028 With MEM_TIMEOUT_EN, reaching TIMEOUT_CYCLES SHALL force DONE, with busErr=1 for that DONE cycle and dataMemOut=0 if the access was a read.
REQ-029 With MEM_TIMEOUT_EN, bus_ready arriving on the same cycle the count expires SHALL complete normally, with busErr=0.
REQ-030 Without MEM_TIMEOUT_EN, REQ SHALL wait indefinitely, busErr SHALL be tied 0, and no counter SHALL exist.

Verification
REQ-031 Read at 0x0000_0104 with bus_ready tied 1 and bus_rdata=0xDEADBEEF -> bus_addr=0x104, bus_be=4'b1111, stall high for 2 cycles, dataMemOut=0xDEADBEEF at N+2.
REQ-032 Write of 0x0000_00AB at address 0x13 with maskByte=4'b1000 and bus_ready delayed 3 cycles -> bus_addr=0x10, bus_we=1, bus_be=4'b1000 held stable 4 cycles, stall high 5 cycles, dataMemOut unchanged.
REQ-033 Write with maskByte=0 -> bus_valid never asserts and stall stays 0.
REQ-034 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and bus_ready held 0 on a read -> DONE after 4 REQ cycles, busErr pulses 1 cycle, dataMemOut=0; also bus_ready=1 on the 4th cycle -> normal completion with busErr=0.
REQ-035 rst asserted mid-REQ -> bus_valid=0 and dataMemOut=0 in the same cycle without a clock edge; the next read completes normally.

Source files
------------

// File: rtl/mem_bus_bridge.sv
// Memory-controller to simple valid/ready bus bridge: three-state IDLE/REQ/DONE handshake.
// Optional bus timeout is enabled with `define MEM_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module mem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] dataMemIn,
  input  logic [3:0]  maskByte,
  output logic [31:0] dataMemOut,
  output logic        stall,
  output logic        busErr,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state_reg;
  logic   req_accept;
  logic   timeout_hit;
  logic   unused_addr_bits;

  // A write with no byte enables is a no-op and never reaches the bus.
  assign req_accept       = (read | write) & ~(write & (maskByte == 4'b0000));
  assign stall            = ((state_reg == IDLE) & req_accept) | (state_reg == REQ);
  assign unused_addr_bits = ^address[1:0];

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] timeout_cnt_reg;

  // A response on the expiring cycle still wins over the timeout.
  assign timeout_hit = ~bus_ready & ((timeout_cnt_reg + 8'd1) == TIMEOUT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt_reg <= 8'd0;
      busErr          <= 1'b0;
    end else begin
      busErr <= 1'b0;
      case (state_reg)
        IDLE: if (req_accept) timeout_cnt_reg <= 8'd0;
        REQ: begin
          if (!bus_ready) timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
          if (timeout_hit) busErr <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign busErr      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      bus_be     <= 4'd0;
      dataMemOut <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_accept) begin
            bus_valid <= 1'b1;
            bus_we    <= write;
            bus_addr  <= {address[31:2], 2'b00};
            bus_wdata <= dataMemIn;
            bus_be    <= write ? maskByte : 4'b1111;
            state_reg <= REQ;
          end
        end
        REQ: begin
          // bus_* stay frozen until the bus accepts or the timeout aborts.
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (!bus_we) dataMemOut <= bus_rdata;
            state_reg <= DONE;
          end else if (timeout_hit) begin
            bus_valid <= 1'b0;
            if (!bus_we) dataMemOut <= 32'd0;
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
